dm_abscmd_seq: RTL

- Abstract-command sequencer inside the debug module (DM).
- Accepts a DMI write to the `command` register and decodes the RISC-V abstract command.
- Selects the debug-ROM routine entry address and drives the ROM patch fields `fix_reg`/`fix_size`.
- Releases the halted hart into the routine, tracks completion and maintains `abstractcs.busy`/`cmderr`. Optionally chains a program-buffer run (postexec).

---
 rtl/dm_abscmd_seq.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_abscmd_seq.sv
// ---------------------------------------------------------------------------
// dm_abscmd_seq
//
// Abstract-command sequencer of the RISC-V debug module. A DMI write to the
// `command` register is latched and decoded. Access register / access memory
// commands select a debug-ROM routine entry point and the ROM patch fields,
// then release the halted hart with a one-cycle `go`. Completion or exception
// pulses from the hart finish the command, optionally chaining a
// program-buffer run (postexec). abstractcs.busy / cmderr are maintained here.
//
// Optional feature (macro DM_ABSCMD_TIMEOUT_EN): a watchdog counter aborts a
// WAIT state with cmderr = 7 after TIMEOUT_CYC cycles. Without the macro the
// WAIT states wait indefinitely.
//
// Parameters:
//   ENTRY_W      width of the routine entry address
//   PROGBUF_ADDR entry address of the program buffer
//   TIMEOUT_CYC  WAIT-state cycle budget (timeout build only)
//
// Ports:
//   clk          DM clock
//   rstn         asynchronous active-low reset
//   cmd_valid    one-cycle strobe, DMI write to `command`
//   cmd_data     command value
//   cmderr_clr   write-1-to-clear mask for cmderr
//   hart_halted  selected hart is halted
//   hart_done    one-cycle pulse, routine reached its "done" exit
//   hart_exc     one-cycle pulse, exception taken in debug code
//   busy         abstractcs.busy
//   cmderr       abstractcs.cmderr
//   go           one-cycle pulse, hart jumps to entry_addr
//   entry_addr   routine start address
//   fix_reg      ROM patch register field
//   fix_size     ROM patch size field (load/store funct3)
// ---------------------------------------------------------------------------
module dm_abscmd_seq #(
    parameter int                 ENTRY_W      = 10,
    parameter logic [ENTRY_W-1:0] PROGBUF_ADDR = ENTRY_W'('h300),
    parameter int                 TIMEOUT_CYC  = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    input  logic [31:0]        cmd_data,
    input  logic [2:0]         cmderr_clr,
    input  logic               hart_halted,
    input  logic               hart_done,
    input  logic               hart_exc,
    output logic               busy,
    output logic [2:0]         cmderr,
    output logic               go,
    output logic [ENTRY_W-1:0] entry_addr,
    output logic [11:0]        fix_reg,
    output logic [1:0]         fix_size
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_GO_CMD,
        S_WAIT_CMD,
        S_GO_PB,
        S_WAIT_PB,
        S_DONE
    } state_t;

    // cmderr codes
    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_EXC     = 3'd3;
    localparam logic [2:0] ERR_HALT    = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    // Debug-ROM routine entry points (write / read flavour)
    localparam logic [ENTRY_W-1:0] A_S0_WR   = ENTRY_W'('h100);
    localparam logic [ENTRY_W-1:0] A_S0_RD   = ENTRY_W'('h13c);
    localparam logic [ENTRY_W-1:0] A_S1_WR   = ENTRY_W'('h114);
    localparam logic [ENTRY_W-1:0] A_S1_RD   = ENTRY_W'('h150);
    localparam logic [ENTRY_W-1:0] A_GPR_WR  = ENTRY_W'('h128);
    localparam logic [ENTRY_W-1:0] A_GPR_RD  = ENTRY_W'('h160);
    localparam logic [ENTRY_W-1:0] A_DPC_WR  = ENTRY_W'('h170);
    localparam logic [ENTRY_W-1:0] A_DPC_RD  = ENTRY_W'('h1a8);
    localparam logic [ENTRY_W-1:0] A_CSR_WR  = ENTRY_W'('h184);
    localparam logic [ENTRY_W-1:0] A_CSR_RD  = ENTRY_W'('h1bc);
    localparam logic [ENTRY_W-1:0] A_MEM_WR  = ENTRY_W'('h1dc);
    localparam logic [ENTRY_W-1:0] A_MEM_RD  = ENTRY_W'('h1f8);

    state_t             r_state;
    state_t             w_state_nxt;

    // Latched command fields
    logic [7:0]         r_cmdtype;
    logic [2:0]         r_size;
    logic               r_postexec;
    logic               r_transfer;
    logic               r_write;
    logic [15:0]        r_regno;

    logic [2:0]         r_cmderr;
    logic [2:0]         w_cmderr_nxt;
    logic [ENTRY_W-1:0] r_entry;
    logic [11:0]        r_fix_reg;
    logic [1:0]         r_fix_size;

    logic               w_err_set;
    logic [2:0]         w_err_code;
    logic               w_load_route;
    logic               w_load_pb;
    logic               w_busy_viol;
    logic               w_timeout;

    logic [ENTRY_W-1:0] w_route_entry;
    logic [11:0]        w_route_fix_reg;

    // aampostincrement and the reserved bit have no effect here
    logic               w_unused_cmd_bits;
    assign w_unused_cmd_bits = ^{cmd_data[23], cmd_data[19]};

    // -----------------------------------------------------------------------
    // Decode helpers on the latched command
    // -----------------------------------------------------------------------
    logic w_is_reg, w_is_mem, w_is_gpr, w_is_csr;
    logic w_reg_size_bad, w_reg_regno_bad, w_mem_size_bad;

    assign w_is_reg        = (r_cmdtype == 8'd0);
    assign w_is_mem        = (r_cmdtype == 8'd2);
    assign w_is_gpr        = (r_regno[15:5] == 11'h080);   // 0x1000-0x101F
    assign w_is_csr        = (r_regno[15:12] == 4'h0);     // 0x0000-0x0FFF
    assign w_reg_size_bad  = w_is_reg && r_transfer && (r_size != 3'd2);
    assign w_reg_regno_bad = w_is_reg && r_transfer && !(w_is_gpr || w_is_csr);
    assign w_mem_size_bad  = w_is_mem && (r_size > 3'd2);

    assign w_busy_viol     = cmd_valid && (r_state != S_IDLE);

    // -----------------------------------------------------------------------
    // Optional WAIT-state watchdog
    // -----------------------------------------------------------------------
`ifdef DM_ABSCMD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 12) ? $clog2(TIMEOUT_CYC + 1) : 12;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_in_wait;

    assign w_in_wait = (r_state == S_WAIT_CMD) || (r_state == S_WAIT_PB);
    // Fires in the TIMEOUT_CYC-th WAIT cycle; the counter starts at 0.
    assign w_timeout = w_in_wait && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_GO_CMD) || (r_state == S_GO_PB)) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and control strobes
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_err_set    = 1'b0;
        w_err_code   = 3'd0;
        w_load_route = 1'b0;
        w_load_pb    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_state_nxt = S_DECODE;
            end

            S_DECODE: begin
                w_state_nxt = S_DONE;
                if (!(w_is_reg || w_is_mem)) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_NOTSUP;
                end else if (!hart_halted) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_HALT;
                end else if (w_reg_size_bad || w_reg_regno_bad || w_mem_size_bad) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_NOTSUP;
                end else if (w_is_reg && !r_transfer) begin
                    // No transfer: only the program buffer may run.
                    if (r_postexec) begin
                        w_state_nxt = S_GO_PB;
                        w_load_pb   = 1'b1;
                    end
                end else begin
                    w_state_nxt  = S_GO_CMD;
                    w_load_route = 1'b1;
                end
            end

            S_GO_CMD: w_state_nxt = S_WAIT_CMD;

            S_WAIT_CMD: begin
                // Exception beats done; done beats the watchdog.
                if (hart_exc) begin
                    w_err_set   = 1'b1;
                    w_err_code  = ERR_EXC;
                    w_state_nxt = S_DONE;
                end else if (hart_done) begin
                    if (r_postexec) begin
                        w_state_nxt = S_GO_PB;
                        w_load_pb   = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_err_code  = ERR_TIMEOUT;
                    w_state_nxt = S_DONE;
                end
            end

            S_GO_PB: w_state_nxt = S_WAIT_PB;

            S_WAIT_PB: begin
                if (hart_exc) begin
                    w_err_set   = 1'b1;
                    w_err_code  = ERR_EXC;
                    w_state_nxt = S_DONE;
                end else if (hart_done) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_err_code  = ERR_TIMEOUT;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: w_state_nxt = S_IDLE;

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Routine selection from the latched command
    // -----------------------------------------------------------------------
    always_comb begin
        w_route_entry   = A_MEM_RD;
        w_route_fix_reg = r_fix_reg;   // memory commands leave fix_reg alone
        if (w_is_mem) begin
            w_route_entry = r_write ? A_MEM_WR : A_MEM_RD;
        end else if (w_is_gpr) begin
            w_route_fix_reg = {7'b0, r_regno[4:0]};
            if (r_regno == 16'h1008)      w_route_entry = r_write ? A_S0_WR  : A_S0_RD;
            else if (r_regno == 16'h1009) w_route_entry = r_write ? A_S1_WR  : A_S1_RD;
            else                          w_route_entry = r_write ? A_GPR_WR : A_GPR_RD;
        end else begin
            w_route_fix_reg = r_regno[11:0];
            if (r_regno == 16'h07B1) w_route_entry = r_write ? A_DPC_WR : A_DPC_RD;
            else                     w_route_entry = r_write ? A_CSR_WR : A_CSR_RD;
        end
    end

    // -----------------------------------------------------------------------
    // cmderr: W1C every cycle; an error is recorded only while cmderr is 0,
    // and a recorded error overrides a same-cycle clear.
    // -----------------------------------------------------------------------
    always_comb begin
        w_cmderr_nxt = r_cmderr & ~cmderr_clr;
        if (r_cmderr == 3'd0) begin
            if (w_err_set)        w_cmderr_nxt = w_err_code;
            else if (w_busy_viol) w_cmderr_nxt = ERR_BUSY;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmdtype  <= '0;
            r_size     <= '0;
            r_postexec <= 1'b0;
            r_transfer <= 1'b0;
            r_write    <= 1'b0;
            r_regno    <= '0;
            r_cmderr   <= '0;
            r_entry    <= '0;
            r_fix_reg  <= '0;
            r_fix_size <= '0;
        end else begin
            r_cmderr <= w_cmderr_nxt;

            if ((r_state == S_IDLE) && cmd_valid) begin
                r_cmdtype  <= cmd_data[31:24];
                r_size     <= cmd_data[22:20];
                r_postexec <= cmd_data[18];
                r_transfer <= cmd_data[17];
                r_write    <= cmd_data[16];
                r_regno    <= cmd_data[15:0];
            end

            if (w_load_route) begin
                r_entry    <= w_route_entry;
                r_fix_reg  <= w_route_fix_reg;
                r_fix_size <= r_size[1:0];
            end else if (w_load_pb) begin
                r_entry    <= PROGBUF_ADDR;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy       = (r_state != S_IDLE);
    assign go         = (r_state == S_GO_CMD) || (r_state == S_GO_PB);
    assign cmderr     = r_cmderr;
    assign entry_addr = r_entry;
    assign fix_reg    = r_fix_reg;
    assign fix_size   = r_fix_size;

endmodule
